// File: rtl/fxp_addsub_arb_pkg.sv
// Shared types and constants for the fxp_addsub arbitration wrapper.
package fxp_addsub_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int                CNT_W   = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

endpackage

// File: rtl/fxp_addsub.sv
// Signed fixed-point adder/subtractor: aligns binary points, optionally rounds
// half-up when dropping fraction bits, and saturates to the output format.
module fxp_addsub #(
  parameter int A_width_int       = 8,
  parameter int A_width_frac      = 8,
  parameter int B_width_int       = 8,
  parameter int B_width_frac      = 8,
  parameter int output_width_int  = 8,
  parameter int output_width_frac = 8,
  parameter int ROUND             = 1
) (
  input  logic [A_width_int+A_width_frac-1:0]           in_a,
  input  logic [B_width_int+B_width_frac-1:0]           in_b,
  input  logic                                          sub,
  output logic [output_width_int+output_width_frac-1:0] out,
  output logic                                          overflow
);

  localparam int FI = (A_width_frac > B_width_frac) ? A_width_frac : B_width_frac;
  // Two guard bits: one for the add/sub carry, one for the rounding increment.
  localparam int II = ((A_width_int > B_width_int) ? A_width_int : B_width_int) + 2;
  localparam int SW = II + FI;
  localparam int OW = output_width_int + output_width_frac;
  localparam int RW = II + output_width_frac;

  logic signed [SW-1:0] a_ext, b_ext, sum;
  logic signed [RW-1:0] res;

  assign a_ext = SW'(signed'(in_a)) <<< (FI - A_width_frac);
  assign b_ext = SW'(signed'(in_b)) <<< (FI - B_width_frac);
  assign sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);

  if (output_width_frac >= FI) begin : g_frac_up
    assign res = RW'(sum) <<< (output_width_frac - FI);
  end else begin : g_frac_down
    localparam int SH   = FI - output_width_frac;
    localparam int HALF = (ROUND != 0) ? (1 << (SH - 1)) : 0;
    logic signed [SW-1:0] biased;
    logic                 unused_low;
    assign biased     = sum + SW'(HALF);
    assign res        = biased[SW-1:SH];
    assign unused_low = ^biased[SH-1:0];
  end

  if (RW > OW) begin : g_sat
    logic [RW-OW:0] top;
    assign top      = res[RW-1:OW-1];
    assign overflow = !((&top) || !(|top));
    assign out      = !overflow ? res[OW-1:0]
                    : (res[RW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});
  end else begin : g_fit
    assign overflow = 1'b0;
    assign out      = OW'(res);
  end

endmodule

// File: rtl/fxp_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module fxp_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/fxp_addsub_arb.sv
// Shares one fxp_addsub among NUM_REQ valid/ready requesters; one operation in
// flight, result held with the requester ID until the consumer accepts it.
module fxp_addsub_arb
  import fxp_addsub_arb_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int ID_W              = 2,
  parameter int A_width_int       = 8,
  parameter int A_width_frac      = 8,
  parameter int B_width_int       = 8,
  parameter int B_width_frac      = 8,
  parameter int output_width_int  = 8,
  parameter int output_width_frac = 8,
  parameter int ROUND             = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rstn,
  input  logic [NUM_REQ-1:0]                                    req_valid,
  output logic [NUM_REQ-1:0]                                    req_ready,
  input  logic [NUM_REQ*(A_width_int+A_width_frac)-1:0]         req_ina,
  input  logic [NUM_REQ*(B_width_int+B_width_frac)-1:0]         req_inb,
  input  logic [NUM_REQ-1:0]                                    req_sub,
  output logic                                                  rsp_valid,
  input  logic                                                  rsp_ready,
  output logic [ID_W-1:0]                                       rsp_id,
  output logic [output_width_int+output_width_frac-1:0]         rsp_data,
  output logic                                                  rsp_overflow,
  output logic [CNT_W-1:0]                                      ovf_count,
  input  logic                                                  clr_count
);

  localparam int AW = A_width_int + A_width_frac;
  localparam int BW = B_width_int + B_width_frac;
  localparam int OW = output_width_int + output_width_frac;

  arb_state_e          state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, op_id, grant_idx;
  logic [AW-1:0]       op_a;
  logic [BW-1:0]       op_b;
  logic                op_sub;
  logic [NUM_REQ-1:0]  grant;
  logic                arb_en, xfer;
  logic [OW-1:0]       sum;
  logic                sum_ovf;

  fxp_rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  fxp_addsub #(
    .A_width_int       (A_width_int),
    .A_width_frac      (A_width_frac),
    .B_width_int       (B_width_int),
    .B_width_frac      (B_width_frac),
    .output_width_int  (output_width_int),
    .output_width_frac (output_width_frac),
    .ROUND             (ROUND)
  ) u_addsub (
    .in_a     (op_a),
    .in_b     (op_b),
    .sub      (op_sub),
    .out      (sum),
    .overflow (sum_ovf)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    // Gated by rstn so req_ready is also held low while reset is asserted.
    arb_en    = 1'b0;
    case (state)
      IDLE: begin
        arb_en = rstn;
        if (xfer) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand registers are reset too, so the adder never sees X after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_sub       <= 1'b0;
      op_id        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          op_a   <= req_ina[grant_idx*AW +: AW];
          op_b   <= req_inb[grant_idx*BW +: BW];
          op_sub <= req_sub[grant_idx];
          op_id  <= grant_idx;
          rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        EXEC: begin
          rsp_data     <= sum;
          rsp_overflow <= sum_ovf;
          rsp_id       <= op_id;
          rsp_valid    <= 1'b1;
        end
        RESP:    if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ovf_count <= '0;
    else if (clr_count)
      ovf_count <= '0;
    else if (rsp_valid && rsp_ready && rsp_overflow && ovf_count != CNT_MAX)
      ovf_count <= ovf_count + 1'b1;
  end

endmodule

// File: tb/tb_fxp_addsub_arb.sv
// Self-checking bench for fxp_addsub_arb: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_fxp_addsub_arb;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      req_valid, req_ready, req_sub;
  logic [N*DW-1:0]   req_ina, req_inb;
  logic              rsp_valid, rsp_ready, rsp_overflow, clr_count;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;
  logic [7:0]        ovf_count;

  always #5 clk = ~clk;

  fxp_addsub_arb dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ina      (req_ina),
    .req_inb      (req_inb),
    .req_sub      (req_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .ovf_count    (ovf_count),
    .clr_count    (clr_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: one outstanding op, response visible one edge after the op is issued.
  typedef struct {
    int         id;
    logic [15:0] data;
    logic       ovf;
  } rsp_t;

  int   m_ptr, m_age, m_cnt, n_rsp, last_g;
  bit   m_busy;
  rsp_t m_rsp;
  int   grants[$];

  function automatic rsp_t ref_op(input int id, input logic [15:0] a, input logic [15:0] b,
                                  input logic s);
    int   r;
    rsp_t x;
    r = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    x.id  = id;
    x.ovf = (r > 32767) || (r < -32768);
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    x.data = r[15:0];
    return x;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    req_ina[i*DW +: DW] = a;
    req_inb[i*DW +: DW] = b;
    req_sub[i]          = s;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = 1'b0;
    m_age  = 0;
    m_cnt  = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    int           g;
    logic [N-1:0] exp_ready;
    bit           exp_rv;
    @(negedge clk);
    g         = m_busy ? -1 : rr_pick(req_valid, m_ptr);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_rv = m_busy && (m_age >= 1);
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      check("rsp_id", rsp_id, m_rsp.id);
      check("rsp_data", rsp_data, m_rsp.data);
      check("rsp_overflow", rsp_overflow, m_rsp.ovf);
    end
    check("ovf_count", ovf_count, m_cnt);
    last_g = g;
    if (clr_count) m_cnt = 0;
    else if (exp_rv && rsp_ready && m_rsp.ovf && m_cnt < 255) m_cnt++;
    if (m_busy) begin
      if (exp_rv && rsp_ready) begin
        m_busy = 1'b0;
        n_rsp++;
      end else m_age = 1;
    end else if (g >= 0) begin
      m_rsp  = ref_op(g, req_ina[g*DW +: DW], req_inb[g*DW +: DW], req_sub[g]);
      m_busy = 1'b1;
      m_age  = 0;
      m_ptr  = (g + 1) % N;
      grants.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random(input int g);
    for (int i = 0; i < N; i++) begin
      if (i == g || !req_valid[i]) begin
        req_valid[i] = ($urandom_range(99) < 60);
        set_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
      end else if ($urandom_range(99) < 8) begin
        req_valid[i] = 1'b0;
      end
    end
    rsp_ready = ($urandom_range(99) < 70);
    clr_count = ($urandom_range(99) < 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int target;
    rstn = 1'b0; req_valid = '0; req_ina = '0; req_inb = '0; req_sub = '0;
    rsp_ready = 1'b0; clr_count = 1'b0; n_rsp = 0; last_g = -1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_ovf", rsp_overflow, 0);
    check("rst_ovf_count", ovf_count, 0);
    rstn = 1'b1;

    // Single add on requester 0: 1.5 + 2.25 = 3.75
    rsp_ready = 1'b1;
    set_op(0, 16'h0180, 16'h0240, 1'b0);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    check("add_valid", rsp_valid, 1);
    check("add_data", rsp_data, 16'h03C0);
    check("add_id", rsp_id, 0);
    check("add_ovf", rsp_overflow, 0);
    cycle();

    // Subtract on requester 2: 1.0 - 3.0 = -2.0
    set_op(2, 16'h0100, 16'h0300, 1'b1);
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    cycle();
    check("sub_data", rsp_data, 16'hFE00);
    check("sub_id", rsp_id, 2);
    cycle();

    // Backpressure: response held for 10 cycles while everyone else is waiting
    set_op(0, 16'h0011, 16'h0022, 1'b0);
    set_op(1, 16'h0010, 16'h0020, 1'b1);
    set_op(2, 16'h1000, 16'h0001, 1'b0);
    set_op(3, 16'h0005, 16'h0003, 1'b1);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    cycle();
    req_valid = '1;
    cycle();
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 16'hFFF0);
      check("bp_id", rsp_id, 1);
      check("bp_ready", req_ready, 0);
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_regrant", req_ready, 4'b0100);
    req_valid = '0;
    repeat (3) cycle();

    // Overflow: 127 + 2 saturates; 257 accepted results saturate the counter
    set_op(3, 16'h7F00, 16'h0200, 1'b0);
    req_valid = 4'b1000;
    target = n_rsp + 257;
    for (int k = 0; k < 257 * 3 + 30 && n_rsp < target; k++) cycle();
    check("ovf_rsp_count", n_rsp, target);
    check("ovf_sat", ovf_count, 255);
    check("ovf_data", rsp_data, 16'h7FFF);
    for (int k = 0; k < 10 && rsp_valid !== 1'b1; k++) cycle();
    check("clr_wait", rsp_valid, 1);
    clr_count = 1'b1;
    cycle();
    clr_count = 1'b0;
    check("clr_priority", ovf_count, 0);
    target = n_rsp + 1;
    for (int k = 0; k < 10 && n_rsp < target; k++) cycle();
    check("ovf_after_clr", ovf_count, 1);

    // Async reset while an operation is in EXEC
    for (int k = 0; k < 10 && !(m_busy && m_age == 0); k++) cycle();
    check("rst_in_exec", m_busy && m_age == 0, 1);
    rstn = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_id", rsp_id, 0);
    check("arst_rsp_data", rsp_data, 0);
    check("arst_rsp_ovf", rsp_overflow, 0);
    check("arst_ovf_count", ovf_count, 0);
    model_reset();
    for (int i = 0; i < N; i++) set_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
    req_valid = '1;
    #2;
    rstn = 1'b1;

    // Fairness with everyone valid: 0,1,2,3,0,1
    grants.delete();
    for (int k = 0; k < 40 && grants.size() < 6; k++) cycle();
    check("fair_count", grants.size(), 6);
    for (int k = 0; k < 6 && k < grants.size(); k++) check("fair_order", grants[k], k % N);

    // Randomized traffic with random backpressure, drops and counter clears
    for (int k = 0; k < 1500; k++) begin
      cycle();
      drive_random(last_g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fxp_addsub_arb.md
Name: fxp_addsub_arb

Overview:
- Shares one fxp_addsub instance among NUM_REQ requesters.
- Each requester has a valid/ready operand port. A round-robin grant picks one requester, its operands are registered and applied to the shared adder, and the result is held with the requester ID until the consumer accepts it.
- One operation in flight at a time.
- Sits between the multiple fixed-point producers (filter taps, accumulators) and a single result consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, 2, requester ID width; must equal max(1, clog2(NUM_REQ))
- A_width_int, 8, integer bits of operand a
- A_width_frac, 8, fraction bits of operand a
- B_width_int, 8, integer bits of operand b
- B_width_frac, 8, fraction bits of operand b
- output_width_int, 8, integer bits of result
- output_width_frac, 8, fraction bits of result
- ROUND, 1, passed to fxp_addsub

Ports:
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_ina  in  NUM_REQ*(A_width_int+A_width_frac)  packed operand a; requester i at slice i
- req_inb  in  NUM_REQ*(B_width_int+B_width_frac)  packed operand b
- req_sub  in  NUM_REQ  1 = a-b, 0 = a+b
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester that issued the result
- rsp_data  out  output_width_int+output_width_frac  result from fxp_addsub
- rsp_overflow  out  1  overflow flag from fxp_addsub
- ovf_count  out  8  saturating count of overflowed results accepted by the consumer
- clr_count  in  1  synchronous clear of ovf_count

Behaviour:
- Reset values (async on rstn=0):
  - state=IDLE, rr pointer=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_overflow=0, ovf_count=0.
  - Operand registers = 0.
- FSM states:
  - IDLE: req_ready = one-hot round-robin grant over req_valid, combinational. A transfer is req_valid[i] & req_ready[i].
    - On transfer: latch ina/inb/sub/id of i; rr pointer <= (i+1) mod NUM_REQ; go to EXEC.
    - With no valid request: stay in IDLE; pointer unchanged.
  - EXEC: req_ready=0. Registered operands drive fxp_addsub combinationally. On the edge, capture out/overflow into rsp_data/rsp_overflow, set rsp_valid=1 and rsp_id=latched id; go to RESP.
  - RESP: req_ready=0. rsp_valid=1 and rsp_* are held stable.
    - On rsp_ready=1: rsp_valid <= 0 and go to IDLE.
    - With rsp_ready=0: stay in RESP indefinitely.
- Round-robin:
  - Search starts at the rr pointer and wraps from NUM_REQ-1 to 0.
  - The first valid requester found wins.
  - Grant is never given to a requester with req_valid=0.
- Latency and throughput:
  - Transfer at edge t gives rsp_valid=1 after edge t+1.
  - Maximum throughput is one op per 3 cycles with rsp_ready tied high.
- Requesters must hold operands stable while req_valid=1 and ready=0. Dropping req_valid before grant is permitted; no grant results.
- ovf_count:
  - Increments when rsp_valid & rsp_ready & rsp_overflow.
  - Saturates at 255.
  - clr_count has priority over increment in the same cycle.
- Arithmetic: widths, sign extension, rounding and saturation are entirely those of fxp_addsub with the given parameters. No further arithmetic is performed in this block.
- Reset mid-operation: any in-flight op is discarded, no response is produced, and the pointer returns to 0.

Decomposition:
- Package fxp_addsub_arb_pkg holds the state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) and the counter width localparam.
- Sub-module fxp_rr_arbiter (parameter N):
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant and encoded grant index.
  - Purely combinational.
- The top level contains the FSM, operand/result registers, the counter, and a single fxp_addsub instance.

Test Plan:
- Single add: req 0, ina=0x0180 (1.5), inb=0x0240 (2.25), sub=0, rsp_ready=1.
  - Expect rsp_valid two edges after the transfer, rsp_data=0x03C0, rsp_id=0, rsp_overflow=0.
- Subtract: req 2, ina=0x0100, inb=0x0300, sub=1.
  - Expect rsp_data=0xFE00 (-2.0), rsp_id=2.
- Fairness: all four requesters valid continuously, rsp_ready=1.
  - Expect grant order 0,1,2,3,0,1; no requester granted twice before the others.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - Expect rsp_valid/rsp_data/rsp_id stable and req_ready=0 throughout.
  - The next grant occurs only in the cycle after the rsp_ready=1 handshake.
- Overflow count: ina=0x7F00, inb=0x0200, sub=0, repeated 257 times.
  - Expect rsp_overflow=1 each time and ovf_count saturating at 255.
  - clr_count pulse with a simultaneous overflow handshake gives ovf_count=0.
- Async reset: assert rstn=0 while in EXEC.
  - Expect all outputs 0 immediately.
  - After release, first grant to requester 0 when all requesters are valid.
